// File: rtl/operand_sweeper_pkg.sv
// Shared types and constants for the operand sweeper.
package operand_sweeper_pkg;

   localparam int DEF_WIDTH = 5;
   localparam int CNT_W     = 2 * DEF_WIDTH;
   localparam int PAIRS     = 1 << CNT_W;

   typedef logic [CNT_W-1:0] count_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/operand_sweeper_if.sv
// Control and operand bus between the sweeper and the unit under sweep.
interface operand_sweeper_if
   import operand_sweeper_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic                 start;
   logic                 abort;
   logic                 step;
   logic                 single;
   logic                 ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 valid;
   logic                 last;
   logic [2*WIDTH-1:0]   count;
   logic                 busy;
   logic                 done;

   // The sweeper side: takes control, produces operands and status.
   modport master (
      input  start, abort, step, single, ready,
      output a, b, valid, last, count, busy, done
   );

   // The consumer / controller side.
   modport slave (
      output start, abort, step, single, ready,
      input  a, b, valid, last, count, busy, done
   );
endinterface

// File: rtl/operand_sweeper.sv
// Exhaustive (a, b) operand generator with valid/ready handshake and an
// optional single-step pacing mode.
module operand_sweeper
   import operand_sweeper_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int STEP_MODE_EN = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   operand_sweeper_if.master  bus
);

   localparam int              CW      = 2 * WIDTH;
   localparam logic [CW-1:0]   CNT_MAX = '1;

   state_e          state_q;
   logic [CW-1:0]   count_q;
   logic            single_q;

   // Sweep FSM: abort beats start beats transfer; the counter only moves on
   // an accepted pair and never wraps inside a sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         single_q <= 1'b0;
      end else if (bus.abort) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_q  <= ST_RUN;
                  count_q  <= '0;
                  single_q <= (STEP_MODE_EN != 0) && bus.single;
               end
            end
            ST_RUN: begin
               if (bus.ready) begin
                  if (count_q == CNT_MAX) begin
                     state_q <= ST_DONE;
                  end else begin
                     count_q <= count_q + 1'b1;
                     state_q <= single_q ? ST_WAIT : ST_RUN;
                  end
               end
            end
            ST_WAIT: begin
               if (bus.step) state_q <= ST_RUN;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of the registered state and counter.
   assign bus.valid = (state_q == ST_RUN);
   assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_WAIT);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.last  = (state_q == ST_RUN) && (count_q == CNT_MAX);
   assign bus.count = count_q;
   assign bus.a     = count_q[WIDTH-1:0];
   assign bus.b     = count_q[CW-1:WIDTH];

endmodule

// File: tb/tb_operand_sweeper.sv
// Directed + randomized bench for operand_sweeper with a pair-index model.
module tb_operand_sweeper;
   import operand_sweeper_pkg::*;

   localparam int W  = DEF_WIDTH;
   localparam int NP = 1 << (2 * W);
   localparam int OP = 1 << W;

   logic clk;
   logic rst_n;

   operand_sweeper_if #(.WIDTH(W)) bus ();

   operand_sweeper #(.WIDTH(W), .STEP_MODE_EN(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int exp_n  = 0;   // index of the next pair the model expects to be accepted

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the presented pair against the model, then clock once.
   task automatic mon_cycle();
      if (bus.valid) begin
         chk("pair_a", 32'(bus.a), exp_n % OP);
         chk("pair_b", 32'(bus.b), exp_n / OP);
         chk("pair_count", 32'(bus.count), exp_n);
         chk("pair_last", 32'(bus.last), 32'(exp_n == NP - 1));
         chk("run_done", 32'(bus.done), 0);
         if (bus.ready && !bus.abort) exp_n++;
      end
      tick();
   endtask

   // Run until the model has seen `target` transfers, within a cycle budget.
   task automatic advance(input int target, input bit rnd, input int budget, output int cyc);
      cyc = 0;
      while (exp_n < target && cyc < budget) begin
         bus.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         mon_cycle();
         cyc++;
      end
      bus.ready = 1'b1;
      if (exp_n < target) chk("timeout", exp_n, target);
   endtask

   task automatic do_start(input bit sgl);
      bus.single = sgl;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      bus.single = 1'b0;
      exp_n      = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(bus.valid), 0);
      chk({tag, "_busy"},  32'(bus.busy),  0);
      chk({tag, "_done"},  32'(bus.done),  0);
      chk({tag, "_count"}, 32'(bus.count), 0);
   endtask

   initial begin
      int cyc;
      int c;
      bit pend;
      bit nxt;

      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.step   = 1'b0;
      bus.single = 1'b0;
      bus.ready  = 1'b0;
      rst_n      = 1'b0;
      repeat (2) tick();
      chk_idle("rst");
      chk("rst_last", 32'(bus.last), 0);
      chk("rst_a", 32'(bus.a), 0);
      chk("rst_b", 32'(bus.b), 0);
      rst_n = 1'b1;
      tick();
      chk_idle("idle");

      // Scenario 1: free-run, ready always high.
      bus.ready = 1'b1;
      bus.start = 1'b1;
      chk("s1_pre_valid", 32'(bus.valid), 0);
      tick();
      bus.start = 1'b0;
      exp_n = 0;
      chk("s1_latency_valid", 32'(bus.valid), 1);
      advance(NP, 1'b0, NP + 16, cyc);
      chk("s1_cycles", cyc, NP);
      chk("s1_done", 32'(bus.done), 1);
      chk("s1_valid_after", 32'(bus.valid), 0);
      chk("s1_count_max", 32'(bus.count), NP - 1);
      chk("s1_busy", 32'(bus.busy), 0);
      tick();
      chk("s1_done_level", 32'(bus.done), 1);

      // Scenario 2: re-sweep from DONE with random backpressure.
      do_start(1'b0);
      advance(NP, 1'b1, 20000, cyc);
      chk("s2_done", 32'(bus.done), 1);
      chk("s2_count_max", 32'(bus.count), NP - 1);

      // Scenario 3: single-step, step every 5 cycles.
      do_start(1'b1);
      pend = 1'b1;
      c = 0;
      while (exp_n < 12 && c < 200) begin
         bus.step = (c % 5 == 4);
         chk("s3_valid", 32'(bus.valid), 32'(pend));
         chk("s3_busy", 32'(bus.busy), 1);
         nxt = pend ? 1'b0 : bus.step;
         mon_cycle();
         pend = nxt;
         c++;
      end
      bus.step = 1'b0;
      if (exp_n < 12) chk("s3_timeout", exp_n, 12);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk_idle("s3_abort");

      // Scenario 4: abort at pair 300 together with a transfer.
      do_start(1'b0);
      advance(300, 1'b0, 400, cyc);
      chk("s4_count", 32'(bus.count), 300);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk_idle("s4_abort");
      repeat (3) begin
         tick();
         chk("s4_idle_done", 32'(bus.done), 0);
      end
      do_start(1'b0);
      chk("s4_restart_valid", 32'(bus.valid), 1);
      chk("s4_restart_a", 32'(bus.a), 0);
      chk("s4_restart_b", 32'(bus.b), 0);

      // Scenario 5: asynchronous reset mid-cycle at pair 517.
      advance(517, 1'b0, 600, cyc);
      chk("s5_count", 32'(bus.count), 517);
      #3;
      rst_n = 1'b0;
      #1;
      chk_idle("s5_rst");
      chk("s5_a", 32'(bus.a), 0);
      chk("s5_b", 32'(bus.b), 0);
      chk("s5_last", 32'(bus.last), 0);
      #2;
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("s5_idle_valid", 32'(bus.valid), 0);
         chk("s5_idle_busy", 32'(bus.busy), 0);
      end

      // Scenario 6: start in RUN is ignored; abort+start in DONE -> IDLE.
      do_start(1'b0);
      advance(10, 1'b0, 20, cyc);
      chk("s6_count10", 32'(bus.count), 10);
      bus.start = 1'b1;
      mon_cycle();
      bus.start = 1'b0;
      chk("s6_start_ignored", 32'(bus.count), 11);
      chk("s6_valid", 32'(bus.valid), 1);
      advance(NP, 1'b0, NP + 16, cyc);
      chk("s6_done", 32'(bus.done), 1);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk_idle("s6_abort_start");
      tick();
      chk("s6_stay_idle", 32'(bus.valid), 0);

      // Scenario 7: abort on the last pair while it transfers.
      do_start(1'b0);
      advance(NP - 1, 1'b0, NP + 16, cyc);
      chk("s7_last", 32'(bus.last), 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk_idle("s7_abort_last");
      tick();
      chk("s7_no_done", 32'(bus.done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_sweeper.md
Name: operand_sweeper

Overview:
- Sequential stimulus source that sits directly upstream of the 5-bit two-operand combinational unit `f`, which consumes `a` and `b` and returns `y` and `xe`.
- On `start`, walks the full operand space exhaustively and presents each (a, b) pair with a valid/ready handshake.
- Replaces free-running bench counters so that hardware and bench can sweep `f` at a controlled pace.
- Reports progress (`count`), the final pair (`last`) and completion (`done`).

Parameters:
- WIDTH, 5: bit width of each operand; the sweep covers 2^(2*WIDTH) pairs (1024 at default).
- STEP_MODE_EN, 1: when 1, the `step` input is honoured; when 0, `step` is ignored and the sweep free-runs.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; sampled in IDLE and DONE only.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- step  input  1  in single-step mode, permits exactly one transfer per pulse.
- single  input  1  1 = single-step mode (effective only if STEP_MODE_EN=1); sampled on `start`.
- ready  input  1  downstream accepts the current pair this cycle.
- a  output  WIDTH  operand A = count[WIDTH-1:0].
- b  output  WIDTH  operand B = count[2*WIDTH-1:WIDTH].
- valid  output  1  `a`/`b` are a live pair.
- last  output  1  high with `valid` when count = 2^(2*WIDTH)-1.
- count  output  2*WIDTH  index of the pair currently presented.
- busy  output  1  high in RUN or WAIT.
- done  output  1  level; high in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, count=0, a=0, b=0, valid=0, last=0, busy=0, done=0, single-step latch=0.
- States: IDLE, RUN, WAIT, DONE; 2-bit encoding, one registered state.
- IDLE:
  - valid=0.
  - start=1 -> RUN; count cleared to 0; `single` latched.
- RUN: valid=1.
  - Transfer = valid & ready.
  - On transfer with count<max: count+1; next state is RUN, or WAIT if single-step is latched.
  - On transfer with count=max: -> DONE; count holds at max.
  - No transfer: hold a, b, count (pair must stay stable while valid & !ready).
- WAIT (single-step only):
  - valid=0.
  - step=1 -> RUN next cycle; the new pair appears one cycle after `step`.
- Step-in-RUN rule: in single-step mode, the first pair after `start` is presented without needing `step`.
- DONE:
  - valid=0, done=1, count=max.
  - start=1 -> RUN with count=0 (re-sweep).
- Outputs are all registered or direct decodes of registered state/count.
  - Latency `start` -> first valid = 1 cycle.
  - Back-to-back throughput with ready=1 = 1 pair/cycle; a full sweep at default width = 1024 cycles after `start`.
- Counter is 2*WIDTH bits.
  - Terminal compare is against all-ones; no wrap occurs during a sweep.
  - Wrap to 0 only via a new `start`.
- Simultaneous events, in priority order:
  - abort > start > transfer.
  - abort with transfer on the last pair -> IDLE, done stays 0.
  - start during RUN/WAIT is ignored.
  - step outside WAIT is ignored.
- Reset mid-sweep: immediate return to the reset values; no partial done.

Decomposition:
- Shared package: state enum (IDLE/RUN/WAIT/DONE), localparam PAIRS = 1<<(2*WIDTH), and the count type logic [2*WIDTH-1:0].
- No sub-module is required.
- The separable piece is a tiny `sweep_counter` (clear/enable/terminal flag); keep it inline unless it is reused by a downstream result-capture stage.

Test Plan:
1. Reset, start pulse, ready=1 always -> valid rises 1 cycle after start; pairs (a,b)=(0,0),(1,0)…(31,0),(0,1)…(31,31) over 1024 consecutive cycles; last with (31,31); done=1 on the next cycle; 1024 transfers counted.
2. ready toggled pseudo-randomly -> pair is stable whenever valid & !ready; the transfer sequence is identical to scenario 1; done after exactly 1024 transfers.
3. single=1 at start, step pulsed every 5 cycles -> first pair (0,0) without a step; each subsequent pair appears 1 cycle after its step; valid=0 between steps.
4. abort at count=300, then start -> valid drops the next cycle and count=0 in IDLE; the re-sweep restarts at (0,0); done never asserted by the aborted run.
5. rst_n low asynchronously mid-cycle at count=517 -> all outputs read their reset values before the next clk edge; after release, the block idles until start.
6. start asserted during RUN at count=10, and abort+start together in DONE -> the RUN start is ignored (count continues to 11); the DONE case goes to IDLE (abort wins), done=0.
